dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port Data_Memory between two requesters: the CPU MEM stage and a debug/loader port.
//  The debug port lets the bench or a loader preload or inspect memory while the CPU runs.
//  The memory is modelled with a fixed multi-cycle access latency.
//  The block sequences each access, stalls the CPU pipeline while its access is pending, and counts CPU stall cycles.
// PARAMETERS
//  ADDR_W   5   byte-address width presented to Data_Memory (32 bytes)
//  MEM_LAT  2   cycles an access occupies the memory (>=1)
//  CNT_W    16  width of stall counter
// PORTS
//  clk_i        in   1       clock, rising edge
//  rst_n_i      in   1       asynchronous active-low reset
//  cpu_req_i    in   1       CPU MEM-stage access request (MemRead|MemWrite)
//  cpu_we_i     in   1       1=store word, 0=load word
//  cpu_addr_i   in   32      CPU byte address
//  cpu_wdata_i  in   32      CPU store data
//  cpu_rdata_o  out  32      CPU load data, valid in CPU DONE cycle
//  cpu_stall_o  out  1       freeze PC/IF/ID/EX/MEM while CPU access is incomplete
//  dbg_req_i    in   1       debug request, held until dbg_ack_o
//  dbg_we_i     in   1       debug write enable
//  dbg_addr_i   in   32      debug byte address
//  dbg_wdata_i  in   32      debug write data
//  dbg_rdata_o  out  32      debug read data, valid with dbg_ack_o
//  dbg_ack_o    out  1       one-cycle completion pulse for debug access
//  mem_en_o     out  1       memory access enable
//  mem_we_o     out  1       memory write strobe
//  mem_addr_o   out  ADDR_W  word-aligned byte address
//  mem_wdata_o  out  32      memory write data
//  mem_rdata_i  in   32      memory read data, valid in last ACCESS cycle
//  stall_cnt_o  out  CNT_W   saturating count of cycles with cpu_stall_o=1
// BEHAVIOUR
//  Reset: all outputs are 0, state=IDLE, last_grant=DBG.
//  Reset is applied asynchronously; it aborts any in-flight access and drops mem_en_o/mem_we_o immediately.
//  FSM states: IDLE, ACCESS, DONE.
//  IDLE:
//   - If no request, stay in IDLE.
//   - Otherwise grant one requester and latch owner, we, addr, wdata; go to ACCESS with cnt=MEM_LAT-1.
//   - Simultaneous requests are round-robin: grant the requester that is not last_grant. CPU wins first after reset.
//  ACCESS:
//   - mem_en_o=1 for exactly MEM_LAT cycles; mem_addr_o and mem_wdata_o are stable throughout.
//   - mem_we_o=1 only in the first ACCESS cycle, and only for a write.
//   - Each cycle: cnt decrements. When cnt==0, mem_rdata_i is registered into the response register and the FSM goes to DONE.
//   - A write registers 0 into the response register.
//  DONE (1 cycle):
//   - Owner CPU: cpu_rdata_o = response; cpu_stall_o=0 this cycle so the pipeline advances.
//   - Owner DBG: dbg_ack_o=1 and dbg_rdata_o = response.
//   - last_grant=owner; go to IDLE. The next grant cannot occur before the following IDLE cycle.
//  Latency: a request sampled in IDLE at cycle T completes in DONE at cycle T+1+MEM_LAT.
//   Back-to-back accesses have a throughput of one per MEM_LAT+2 cycles.
//  cpu_stall_o = cpu_req_i & ~(state==DONE & owner==CPU). This is combinational.
//   The CPU therefore stalls in the request cycle itself and while DBG holds the memory.
//  rdata outputs hold their last value outside DONE.
//  Addressing: addr[1:0] are ignored; mem_addr_o = {addr[ADDR_W-1:2],2'b00}. Upper bits are dropped (wrap-around).
//  A request dropped mid-access still completes. The memory write still occurs, the ack/DONE still fires, and the result is discarded.
//  stall_cnt_o increments on every clock edge where cpu_stall_o=1 and saturates at all-ones.
// TESTING
//  1. CPU lw addr 0x00 with mem[0]=5, MEM_LAT=2, no DBG:
//     stall high 3 cycles (req, ACCESS x2); DONE gives cpu_rdata_o=5; stall_cnt_o=3.
//  2. DBG sw 0x08=0x1234 then DBG lw 0x0A:
//     one mem_we_o pulse with mem_addr_o=0x08; second ack returns 0x1234 (alignment check).
//  3. CPU and DBG both request at cycle 0 after reset:
//     CPU granted first; DBG granted at cycle 4; CPU's next request waits for DBG and is then granted.
//  4. Continuous requests on both ports for 20 cycles:
//     grants alternate strictly CPU/DBG; no requester waits more than 2*(MEM_LAT+2) cycles.
//  5. rst_n_i asserted mid-ACCESS of a write:
//     mem_en_o/mem_we_o drop without waiting for a clock edge; no ack; stall_cnt_o=0; FSM restarts in IDLE.
//  6. CNT_W=2 with CPU held stalled behind 3 DBG accesses:
//     stall_cnt_o saturates at 3 and does not wrap.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Data-memory arbiter: one single-port memory shared by the CPU MEM stage and a debug/loader port.
// Each access runs IDLE -> ACCESS (MEM_LAT cycles) -> DONE. Round-robin between simultaneous
// requesters. The block also keeps a saturating count of CPU stall cycles.
module dmem_arbiter #(
  parameter int unsigned ADDR_W  = 5,
  parameter int unsigned MEM_LAT = 2,
  parameter int unsigned CNT_W   = 16
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              cpu_req_i,
  input  logic              cpu_we_i,
  input  logic [31:0]       cpu_addr_i,
  input  logic [31:0]       cpu_wdata_i,
  output logic [31:0]       cpu_rdata_o,
  output logic              cpu_stall_o,
  input  logic              dbg_req_i,
  input  logic              dbg_we_i,
  input  logic [31:0]       dbg_addr_i,
  input  logic [31:0]       dbg_wdata_i,
  output logic [31:0]       dbg_rdata_o,
  output logic              dbg_ack_o,
  output logic              mem_en_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  input  logic [31:0]       mem_rdata_i,
  output logic [CNT_W-1:0]  stall_cnt_o
);

  localparam int unsigned CntW = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CntW-1:0] CntInit = CntW'(MEM_LAT - 1);

  localparam logic OwnCpu = 1'b0;
  localparam logic OwnDbg = 1'b1;

  typedef enum logic [1:0] {
    StIdle,
    StAccess,
    StDone
  } state_e;

  state_e            state_q, state_d;
  logic              owner_q, owner_d;
  logic              last_grant_q, last_grant_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [31:0]       cpu_rdata_q, cpu_rdata_d;
  logic [31:0]       dbg_rdata_q, dbg_rdata_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              grant_dbg;
  logic [31:0]       resp;

  // Byte-lane and above-window address bits are intentionally ignored.
  logic unused_addr;
  assign unused_addr = ^{cpu_addr_i[31:ADDR_W], cpu_addr_i[1:0],
                         dbg_addr_i[31:ADDR_W], dbg_addr_i[1:0]};

  // State and datapath registers; reset aborts any in-flight access.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q      <= StIdle;
      owner_q      <= OwnCpu;
      last_grant_q <= OwnDbg;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
      stall_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
      stall_cnt_q  <= stall_cnt_d;
    end
  end

  // Next-state logic: grant, sequence the access, capture the response.
  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    // DBG wins only when CPU is idle or CPU had the previous grant.
    grant_dbg    = dbg_req_i & (~cpu_req_i | (last_grant_q == OwnCpu));
    // Writes return zero as their response.
    resp         = we_q ? 32'h0 : mem_rdata_i;

    unique case (state_q)
      StIdle: begin
        if (cpu_req_i || dbg_req_i) begin
          state_d = StAccess;
          cnt_d   = CntInit;
          if (grant_dbg) begin
            owner_d = OwnDbg;
            we_d    = dbg_we_i;
            addr_d  = {dbg_addr_i[ADDR_W-1:2], 2'b00};
            wdata_d = dbg_wdata_i;
          end else begin
            owner_d = OwnCpu;
            we_d    = cpu_we_i;
            addr_d  = {cpu_addr_i[ADDR_W-1:2], 2'b00};
            wdata_d = cpu_wdata_i;
          end
        end
      end
      StAccess: begin
        if (cnt_q == '0) begin
          state_d = StDone;
          if (owner_q == OwnCpu) begin
            cpu_rdata_d = resp;
          end else begin
            dbg_rdata_d = resp;
          end
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        last_grant_d = owner_q;
        state_d      = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Combinational outputs derived from the registered state.
  always_comb begin
    mem_en_o    = (state_q == StAccess);
    mem_we_o    = (state_q == StAccess) & we_q & (cnt_q == CntInit);
    mem_addr_o  = addr_q;
    mem_wdata_o = wdata_q;
    cpu_stall_o = cpu_req_i & ~((state_q == StDone) & (owner_q == OwnCpu));
    dbg_ack_o   = (state_q == StDone) & (owner_q == OwnDbg);
    cpu_rdata_o = cpu_rdata_q;
    dbg_rdata_o = dbg_rdata_q;
    stall_cnt_o = stall_cnt_q;
  end

  // Saturating stall-cycle counter.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (cpu_stall_o && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed scoreboard bench for dmem_arbiter: per-port expected-response queues, a small
// memory model, and a second instance with a 2-bit stall counter for saturation.
module tb_dmem_arbiter;

  localparam int unsigned AddrW  = 5;
  localparam int unsigned MemLat = 2;
  localparam int unsigned WaitMax = 2 * (MemLat + 2);

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 1'b0, cpu_we = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        dbg_req = 1'b0, dbg_we = 1'b0;
  logic [31:0] dbg_addr = '0, dbg_wdata = '0;

  logic [31:0]      cpu_rdata, dbg_rdata, mem_wdata, mem_rdata;
  logic             cpu_stall, dbg_ack, mem_en, mem_we;
  logic [AddrW-1:0] mem_addr;
  logic [15:0]      stall_cnt;

  logic [31:0]      s_cpu_rdata, s_dbg_rdata, s_mem_wdata;
  logic             s_cpu_stall, s_dbg_ack, s_mem_en, s_mem_we;
  logic [AddrW-1:0] s_mem_addr;
  logic [1:0]       s_stall_cnt;

  int compared = 0;
  int mismatched = 0;

  logic [31:0] mem [8];
  logic [31:0] ref_mem [8];
  bit          mem_loaded = 1'b0;
  int          we_cnt = 0;
  logic [AddrW-1:0] we_addr = '0;
  bit          grant_log [$];
  logic [31:0] cpu_q [$];
  logic [31:0] dbg_q [$];

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(AddrW), .MEM_LAT(MemLat), .CNT_W(16)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(cpu_rdata), .cpu_stall_o(cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(dbg_rdata), .dbg_ack_o(dbg_ack),
    .mem_en_o(mem_en), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata), .stall_cnt_o(stall_cnt)
  );

  dmem_arbiter #(.ADDR_W(AddrW), .MEM_LAT(MemLat), .CNT_W(2)) dut_sat (
    .clk_i(clk), .rst_n_i(rst_n),
    .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_addr_i(cpu_addr), .cpu_wdata_i(cpu_wdata),
    .cpu_rdata_o(s_cpu_rdata), .cpu_stall_o(s_cpu_stall),
    .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_wdata_i(dbg_wdata),
    .dbg_rdata_o(s_dbg_rdata), .dbg_ack_o(s_dbg_ack),
    .mem_en_o(s_mem_en), .mem_we_o(s_mem_we), .mem_addr_o(s_mem_addr),
    .mem_wdata_o(s_mem_wdata), .mem_rdata_i(mem_rdata), .stall_cnt_o(s_stall_cnt)
  );

  function automatic logic [31:0] init_word(input int i);
    return (i == 0) ? 32'd5 : (32'h1100 + 32'(i));
  endfunction

  // Memory model: combinational read, write on the strobe edge.
  assign mem_rdata = mem[mem_addr[4:2]];

  // Monitor: memory writes and completion order (0 = CPU, 1 = DBG).
  always @(posedge clk) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 8; i++) mem[i] = init_word(i);
      mem_loaded = 1'b1;
    end
    if (mem_we) begin
      mem[mem_addr[4:2]] = mem_wdata;
      we_cnt  = we_cnt + 1;
      we_addr = mem_addr;
    end
    if (cpu_req && !cpu_stall) grant_log.push_back(1'b0);
    if (dbg_ack) grant_log.push_back(1'b1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Caller is at negedge+1; returns at negedge+1 of the cycle after DONE.
  task automatic cpu_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int waits);
    cpu_q.push_back(we ? 32'h0 : ref_mem[addr[4:2]]);
    if (we) ref_mem[addr[4:2]] = wdata;
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    #1;
    waits = 0;
    while (cpu_stall && waits < 50) begin
      @(negedge clk); #1;
      waits++;
    end
    check("cpu_done_in_budget", {31'b0, cpu_stall}, 32'h0);
    check("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    check("cpu_wait_bound", {31'b0, waits <= WaitMax}, 32'h1);
    @(negedge clk); #1;
    cpu_req = 1'b0; cpu_we = 1'b0;
  endtask

  task automatic dbg_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        output int waits);
    dbg_q.push_back(we ? 32'h0 : ref_mem[addr[4:2]]);
    if (we) ref_mem[addr[4:2]] = wdata;
    dbg_req = 1'b1; dbg_we = we; dbg_addr = addr; dbg_wdata = wdata;
    #1;
    waits = 0;
    while (!dbg_ack && waits < 50) begin
      @(negedge clk); #1;
      waits++;
    end
    check("dbg_ack_in_budget", {31'b0, dbg_ack}, 32'h1);
    check("dbg_rdata", dbg_rdata, dbg_q.pop_front());
    check("dbg_wait_bound", {31'b0, waits <= WaitMax}, 32'h1);
    @(negedge clk); #1;
    dbg_req = 1'b0; dbg_we = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask

  initial begin
    int w0, w1, w2, base, wb;
    bit exp_seq [$];
    for (int i = 0; i < 8; i++) ref_mem[i] = init_word(i);

    // Reset state.
    do_reset();
    check("rst_mem_en", {31'b0, mem_en}, 32'h0);
    check("rst_mem_we", {31'b0, mem_we}, 32'h0);
    check("rst_mem_addr", {27'b0, mem_addr}, 32'h0);
    check("rst_ack", {31'b0, dbg_ack}, 32'h0);
    check("rst_stall", {31'b0, cpu_stall}, 32'h0);
    check("rst_cpu_rdata", cpu_rdata, 32'h0);
    check("rst_stall_cnt", {16'b0, stall_cnt}, 32'h0);

    // CPU load from word 0: three stall cycles.
    cpu_op(1'b0, 32'h0, 32'h0, w0);
    check("t1_stall_cycles", w0, MemLat + 1);
    check("t1_stall_cnt", {16'b0, stall_cnt}, 32'd3);
    check("t1_sat_cnt", {30'b0, s_stall_cnt}, 32'd3);

    // DBG store then misaligned load of the same word.
    wb = we_cnt;
    dbg_op(1'b1, 32'h08, 32'h1234, w0);
    check("t2_we_pulses", we_cnt - wb, 1);
    check("t2_we_addr", {27'b0, we_addr}, 32'h08);
    dbg_op(1'b0, 32'h0A, 32'h0, w0);

    // Simultaneous requests after reset: CPU, DBG, CPU.
    do_reset();
    @(negedge clk); #1;
    base = grant_log.size();
    fork
      begin
        cpu_op(1'b0, 32'h04, 32'h0, w0);
        cpu_op(1'b0, 32'h10, 32'h0, w1);
      end
      dbg_op(1'b0, 32'h0C, 32'h0, w2);
    join
    check("t3_dbg_done_cycle", w2, 4 + MemLat + 1);
    check("t3_cpu2_wait", w1, 2 * (MemLat + 2) - 1);
    exp_seq = '{1'b0, 1'b1, 1'b0};
    check("t3_log_len", grant_log.size() - base, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (base + i < grant_log.size()) check("t3_order", {31'b0, grant_log[base+i]},
                                              {31'b0, exp_seq[i]});
    end
    check("t3_stall_cnt", {16'b0, stall_cnt}, 32'd10);

    // Continuous requests on both ports: strict alternation starting with DBG.
    base = grant_log.size();
    fork
      begin
        cpu_op(1'b0, 32'h14, 32'h0, w0);
        cpu_op(1'b0, 32'h23, 32'h0, w0);
        cpu_op(1'b0, 32'h18, 32'h0, w0);
      end
      begin
        dbg_op(1'b0, 32'h1C, 32'h0, w1);
        dbg_op(1'b0, 32'h01, 32'h0, w1);
        dbg_op(1'b0, 32'h3E, 32'h0, w1);
      end
    join
    exp_seq = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    check("t4_log_len", grant_log.size() - base, exp_seq.size());
    for (int i = 0; i < exp_seq.size(); i++) begin
      if (base + i < grant_log.size()) check("t4_order", {31'b0, grant_log[base+i]},
                                              {31'b0, exp_seq[i]});
    end
    check("t4_stall_cnt", {16'b0, stall_cnt}, 32'd31);
    check("t6_sat_cnt", {30'b0, s_stall_cnt}, 32'd3);

    // Reset during the first ACCESS cycle of a DBG write.
    dbg_req = 1'b1; dbg_we = 1'b1; dbg_addr = 32'h0C; dbg_wdata = 32'hDEAD;
    @(posedge clk); #1;
    check("t5_en_before", {31'b0, mem_en}, 32'h1);
    check("t5_we_before", {31'b0, mem_we}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("t5_en_async", {31'b0, mem_en}, 32'h0);
    check("t5_we_async", {31'b0, mem_we}, 32'h0);
    check("t5_stall_cnt", {16'b0, stall_cnt}, 32'h0);
    dbg_req = 1'b0; dbg_we = 1'b0;
    base = grant_log.size();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("t5_no_ack", grant_log.size() - base, 0);
    check("t5_idle_en", {31'b0, mem_en}, 32'h0);
    dbg_op(1'b0, 32'h0C, 32'h0, w0);
    check("t5_restart_latency", w0, MemLat + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
